rf_write_arbiter: RTL and testbench
===================================

Name: rf_write_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters: the ALU result path (ALU) and the load/store unit return path (LSU).
- Each requester uses a valid/ready handshake. The block drives dest, reg_write and write_data into the register file from one registered output stage.
- It also publishes a pending-write mask that the hazard logic uses for stalls.

Parameters:
- XLEN, 32, data width of write_data and of both requester data buses.
- PRIO_MODE, 0, 0 = round-robin; 1 = LSU fixed priority with starvation guard.
- STARVE_LIMIT, 4, in PRIO_MODE=1: consecutive cycles ALU may be valid-but-ungranted before ALU is forced through; range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- alu_valid  input  1  ALU writeback request.
- alu_dest  input  5  ALU destination register.
- alu_data  input  XLEN  ALU write data.
- alu_ready  output  1  ALU request accepted this cycle.
- lsu_valid  input  1  LSU writeback request.
- lsu_dest  input  5  LSU destination register.
- lsu_data  input  XLEN  LSU write data.
- lsu_ready  output  1  LSU request accepted this cycle.
- rf_dest  output  5  to register file dest.
- rf_reg_write  output  1  to register file reg_write.
- rf_write_data  output  XLEN  to register file write_data.
- pending_mask  output  32  bit i set while a write to register i sits in the output stage; bit 0 always 0.
- grant_last  output  1  last granted requester: 0 = ALU, 1 = LSU.

Behaviour:
- Reset (async, immediate):
  - rf_reg_write=0, rf_dest=0, rf_write_data=0, pending_mask=0.
  - grant_last=1, so ALU wins the first tie.
  - Starvation counter = 0.
  - Any output-stage write in flight is discarded and must not be issued.
- Accept rule:
  - At most one requester is accepted per cycle.
  - ready is combinational from valid and arbitration state. It is never asserted without the matching valid.
  - A request is accepted on a cycle where valid && ready.
  - The requester holds dest/data stable until accepted. The arbiter may not deassert a grant mid-cycle.
- Output stage:
  - Always accepts. The register file write has no backpressure.
  - Latency is one cycle: an accepted request is presented on rf_dest/rf_write_data with rf_reg_write=1 in the next cycle.
  - rf_reg_write is a single-cycle pulse per accepted request.
- x0 writes:
  - A request with dest=0 is accepted normally (ready=1) and consumes its arbitration slot.
  - rf_reg_write stays 0 the next cycle, and no pending_mask bit is set.
- pending_mask: equals a one-hot of rf_dest when rf_reg_write=1, else 0.
- Round-robin (PRIO_MODE=0):
  - Only one valid: grant it.
  - Both valid: grant the requester that was not grant_last.
  - grant_last updates only on an accept.
- Fixed priority (PRIO_MODE=1):
  - Both valid: grant LSU, unless the starvation counter equals STARVE_LIMIT, in which case grant ALU.
  - Counter increments each cycle alu_valid && !alu_ready, saturating at STARVE_LIMIT.
  - Counter clears on ALU accept or when alu_valid=0.
- Same dest from both requesters on the same cycle: the granted one writes first, the other on a later cycle. Last write wins in the register file. The arbiter does no merging.
- Idle (no valid): rf_reg_write=0 next cycle. rf_dest/rf_write_data hold their previous values.

Decomposition:
- Shared package rv_pkg holds:
  - REG_ADDR_W=5 and NUM_REGS=32.
  - Requester index constants REQ_ALU=0 and REQ_LSU=1.
  - PRIO_RR=0 and PRIO_FIXED=1.
- One sub-module is natural: rr_arb2, a 2-input arbiter with grant_last state and optional starvation counter.
- The write stage and pending_mask decode stay in rf_write_arbiter.

Test Plan:
- Reset: assert rst mid-cycle while rf_reg_write=1 -> all outputs 0 immediately. grant_last=1, and no write appears after rst drops.
- Single ALU request alu_dest=5, alu_data=0xDEADBEEF -> alu_ready=1 same cycle. Next cycle rf_reg_write=1, rf_dest=5, rf_write_data=0xDEADBEEF, pending_mask=0x00000020.
- Round-robin, both valid continuously for 4 cycles (ALU dest=1, LSU dest=2) -> grants ALU, LSU, ALU, LSU. rf_dest sequence 1,2,1,2 one cycle later.
- x0 drop: LSU request dest=0, data=0x1234 -> lsu_ready=1. Next cycle rf_reg_write=0 and pending_mask=0.
- PRIO_MODE=1, STARVE_LIMIT=4, both valid continuously -> LSU granted 4 cycles, ALU granted on 5th, counter back to 0, then LSU again.
- Same dest=7 both valid, ALU data=0xA, LSU data=0xB, round-robin from reset -> write 0xA then 0xB on consecutive cycles. Register 7 ends at 0xB.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared definitions for the register-file writeback path.
// Provides register-address geometry, requester indices, arbitration mode
// codes and a one-hot decode helper used for the pending-write mask.
package rv_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    localparam int REQ_ALU = 0;
    localparam int REQ_LSU = 1;

    localparam int PRIO_RR    = 0;
    localparam int PRIO_FIXED = 1;

    // Encoding matches the grant_last port: 0 = ALU, 1 = LSU.
    typedef enum logic {
        GNT_ALU = 1'b0,
        GNT_LSU = 1'b1
    } req_e;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] idx);
        return NUM_REGS'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input writeback arbiter.
// Ports:
//   clk, rst        clock and async active-high reset
//   req[1:0]        request vector, index REQ_ALU / REQ_LSU
//   gnt[1:0]        combinational grant, at most one bit set, never without req
//   grant_last      requester granted most recently (0 = ALU, 1 = LSU)
// PRIO_MODE selects round-robin or LSU-first with an ALU starvation guard.
module rr_arb2
    import rv_pkg::*;
#(
    parameter int PRIO_MODE    = PRIO_RR,
    parameter int STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic       grant_last
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    req_e       last_q;
    req_e       last_next;
    logic [3:0] starve_cnt;
    logic [3:0] starve_cnt_next;
    logic       starved;

    assign starved    = (starve_cnt == LIMIT);
    assign grant_last = last_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q     <= GNT_LSU;
            starve_cnt <= '0;
        end else begin
            last_q     <= last_next;
            starve_cnt <= starve_cnt_next;
        end
    end

    always_comb begin
        gnt             = '0;
        last_next       = last_q;
        starve_cnt_next = '0;

        if (req[REQ_ALU] && req[REQ_LSU]) begin
            if (PRIO_MODE == PRIO_FIXED) begin
                if (starved) gnt[REQ_ALU] = 1'b1;
                else         gnt[REQ_LSU] = 1'b1;
            end else begin
                if (last_q == GNT_LSU) gnt[REQ_ALU] = 1'b1;
                else                   gnt[REQ_LSU] = 1'b1;
            end
        end else begin
            gnt = req;
        end

        if (gnt[REQ_ALU])      last_next = GNT_ALU;
        else if (gnt[REQ_LSU]) last_next = GNT_LSU;

        // Counts cycles ALU waits; any idle or accepted ALU cycle restarts it.
        if (PRIO_MODE == PRIO_FIXED && req[REQ_ALU] && !gnt[REQ_ALU]) begin
            starve_cnt_next = starved ? starve_cnt : starve_cnt + 4'd1;
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register file's single write port between the ALU and LSU
// writeback paths through one registered output stage.
// Ports:
//   clk, rst                      clock and async active-high reset
//   alu_valid/dest/data, alu_ready  ALU writeback handshake
//   lsu_valid/dest/data, lsu_ready  LSU writeback handshake
//   rf_dest, rf_reg_write, rf_write_data  register file write port
//   pending_mask                  one-hot of rf_dest while a write is presented
//   grant_last                    last granted requester (0 = ALU, 1 = LSU)
module rf_write_arbiter
    import rv_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int PRIO_MODE    = PRIO_RR,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_dest,
    input  logic [XLEN-1:0]       alu_data,
    output logic                  alu_ready,
    input  logic                  lsu_valid,
    input  logic [REG_ADDR_W-1:0] lsu_dest,
    input  logic [XLEN-1:0]       lsu_data,
    output logic                  lsu_ready,
    output logic [REG_ADDR_W-1:0] rf_dest,
    output logic                  rf_reg_write,
    output logic [XLEN-1:0]       rf_write_data,
    output logic [NUM_REGS-1:0]   pending_mask,
    output logic                  grant_last
);

    logic [1:0]            gnt;
    logic                  accept;
    logic [REG_ADDR_W-1:0] sel_dest;
    logic [XLEN-1:0]       sel_data;
    logic                  sel_real;

    rr_arb2 #(
        .PRIO_MODE    (PRIO_MODE),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arb (
        .clk        (clk),
        .rst        (rst),
        .req        ({lsu_valid, alu_valid}),
        .gnt        (gnt),
        .grant_last (grant_last)
    );

    assign alu_ready = gnt[REQ_ALU];
    assign lsu_ready = gnt[REQ_LSU];
    assign accept    = |gnt;

    assign sel_dest = gnt[REQ_LSU] ? lsu_dest : alu_dest;
    assign sel_data = gnt[REQ_LSU] ? lsu_data : alu_data;
    assign sel_real = accept && (sel_dest != '0);

    // x0 requests are consumed here; the write port keeps showing the last
    // real write so rf_dest/rf_write_data never describe a dropped write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_reg_write  <= 1'b0;
            rf_dest       <= '0;
            rf_write_data <= '0;
        end else begin
            rf_reg_write <= sel_real;
            if (sel_real) begin
                rf_dest       <= sel_dest;
                rf_write_data <= sel_data;
            end
        end
    end

    assign pending_mask = rf_reg_write ? reg_onehot(rf_dest) : '0;

endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;

    typedef struct {
        logic [4:0]  dest;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_rr = 1'b1;
    logic        rst_fp = 1'b1;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_dest = '0;
    logic [31:0] alu_data = '0;
    logic        lsu_valid = 1'b0;
    logic [4:0]  lsu_dest = '0;
    logic [31:0] lsu_data = '0;

    logic        rr_alu_ready, rr_lsu_ready, rr_reg_write, rr_grant_last;
    logic [4:0]  rr_dest;
    logic [31:0] rr_data, rr_mask;
    logic        fp_alu_ready, fp_lsu_ready, fp_reg_write, fp_grant_last;
    logic [4:0]  fp_dest;
    logic [31:0] fp_data, fp_mask;

    int errors = 0;
    int checks = 0;
    exp_t q_rr[$];
    exp_t q_fp[$];
    logic [31:0] rf_model [32];

    always #5 clk = ~clk;

    rf_write_arbiter #(.XLEN(32), .PRIO_MODE(0), .STARVE_LIMIT(4)) dut_rr (
        .clk(clk), .rst(rst_rr),
        .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data), .alu_ready(rr_alu_ready),
        .lsu_valid(lsu_valid), .lsu_dest(lsu_dest), .lsu_data(lsu_data), .lsu_ready(rr_lsu_ready),
        .rf_dest(rr_dest), .rf_reg_write(rr_reg_write), .rf_write_data(rr_data),
        .pending_mask(rr_mask), .grant_last(rr_grant_last)
    );

    rf_write_arbiter #(.XLEN(32), .PRIO_MODE(1), .STARVE_LIMIT(4)) dut_fp (
        .clk(clk), .rst(rst_fp),
        .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data), .alu_ready(fp_alu_ready),
        .lsu_valid(lsu_valid), .lsu_dest(lsu_dest), .lsu_data(lsu_data), .lsu_ready(fp_lsu_ready),
        .rf_dest(fp_dest), .rf_reg_write(fp_reg_write), .rf_write_data(fp_data),
        .pending_mask(fp_mask), .grant_last(fp_grant_last)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one request cycle (entered at posedge+1), check the grant and
    // queue the expected register-file write of whichever side wins.
    task automatic issue(input bit sel, input logic av, input logic [4:0] ad, input logic [31:0] adat,
                         input logic lv, input logic [4:0] ld, input logic [31:0] ldat,
                         input logic [1:0] exp_gnt, input bit track);
        exp_t e;
        alu_valid = av; alu_dest = ad; alu_data = adat;
        lsu_valid = lv; lsu_dest = ld; lsu_data = ldat;
        #1;
        chk(sel ? "fp_alu_ready" : "rr_alu_ready", {31'b0, sel ? fp_alu_ready : rr_alu_ready}, {31'b0, exp_gnt[0]});
        chk(sel ? "fp_lsu_ready" : "rr_lsu_ready", {31'b0, sel ? fp_lsu_ready : rr_lsu_ready}, {31'b0, exp_gnt[1]});
        if (track) begin
            if (exp_gnt[0] && ad != 5'd0) begin e.dest = ad; e.data = adat; end
            if (exp_gnt[1] && ld != 5'd0) begin e.dest = ld; e.data = ldat; end
            if ((exp_gnt[0] && ad != 5'd0) || (exp_gnt[1] && ld != 5'd0)) begin
                if (sel) q_fp.push_back(e);
                else     q_rr.push_back(e);
            end
        end
        @(posedge clk); #1;
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic reset_rr();
        rst_rr = 1'b1;
        @(posedge clk); #1;
        rst_rr = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_rr) begin
            if (rr_reg_write) begin
                if (q_rr.size() == 0) begin
                    chk("rr_unexpected_write_dest", {27'b0, rr_dest}, 32'hFFFF_FFFF);
                end else begin
                    e = q_rr.pop_front();
                    chk("rr_dest", {27'b0, rr_dest}, {27'b0, e.dest});
                    chk("rr_data", rr_data, e.data);
                    chk("rr_mask", rr_mask, 32'h1 << e.dest);
                    rf_model[rr_dest] = rr_data;
                end
            end else begin
                chk("rr_mask_idle", rr_mask, 32'h0);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst_fp) begin
            if (fp_reg_write) begin
                if (q_fp.size() == 0) begin
                    chk("fp_unexpected_write_dest", {27'b0, fp_dest}, 32'hFFFF_FFFF);
                end else begin
                    e = q_fp.pop_front();
                    chk("fp_dest", {27'b0, fp_dest}, {27'b0, e.dest});
                    chk("fp_data", fp_data, e.data);
                    chk("fp_mask", fp_mask, 32'h1 << e.dest);
                end
            end else begin
                chk("fp_mask_idle", fp_mask, 32'h0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 32; i++) rf_model[i] = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_reg_write", {31'b0, rr_reg_write}, 32'h0);
        chk("reset_dest", {27'b0, rr_dest}, 32'h0);
        chk("reset_data", rr_data, 32'h0);
        chk("reset_mask", rr_mask, 32'h0);
        chk("reset_grant_last", {31'b0, rr_grant_last}, 32'h1);
        rst_rr = 1'b0;

        // Reset asserted while a write is on the port discards it.
        issue(0, 1, 5'd3, 32'h0000_0055, 0, 5'd0, 32'h0, 2'b01, 0);
        chk("midrst_pre_write", {31'b0, rr_reg_write}, 32'h1);
        rst_rr = 1'b1;
        #1;
        chk("midrst_reg_write", {31'b0, rr_reg_write}, 32'h0);
        chk("midrst_dest", {27'b0, rr_dest}, 32'h0);
        chk("midrst_data", rr_data, 32'h0);
        chk("midrst_mask", rr_mask, 32'h0);
        chk("midrst_grant_last", {31'b0, rr_grant_last}, 32'h1);
        @(posedge clk); #1;
        rst_rr = 1'b0;
        idle(3);

        // Single ALU request.
        issue(0, 1, 5'd5, 32'hDEAD_BEEF, 0, 5'd0, 32'h0, 2'b01, 1);
        idle(2);

        // Round-robin with both requesters streaming.
        reset_rr();
        issue(0, 1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 2'b01, 1);
        issue(0, 1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 2'b10, 1);
        issue(0, 1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 2'b01, 1);
        issue(0, 1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 2'b10, 1);
        idle(2);

        // x0 write: accepted but never reaches the register file.
        issue(0, 0, 5'd0, 32'h0, 1, 5'd0, 32'h1234, 2'b10, 1);
        idle(2);
        chk("x0_port_holds_dest", {27'b0, rr_dest}, 32'd2);

        // Same destination from both sides: ALU first, then LSU.
        reset_rr();
        issue(0, 1, 5'd7, 32'hA, 1, 5'd7, 32'hB, 2'b01, 1);
        issue(0, 0, 5'd7, 32'hA, 1, 5'd7, 32'hB, 2'b10, 1);
        idle(3);
        chk("same_dest_final_r7", rf_model[7], 32'hB);
        chk("idle_hold_dest", {27'b0, rr_dest}, 32'd7);
        chk("idle_hold_data", rr_data, 32'hB);

        // Fixed priority with starvation guard.
        rst_rr = 1'b1;
        rst_fp = 1'b0;
        for (int i = 0; i < 6; i++)
            issue(1, 1, 5'd3, 32'h33, 1, 5'd4, 32'h44, (i == 4) ? 2'b01 : 2'b10, 1);
        idle(1);
        for (int i = 0; i < 5; i++)
            issue(1, 1, 5'd3, 32'h33, 1, 5'd4, 32'h44, (i == 4) ? 2'b01 : 2'b10, 1);
        idle(3);

        chk("rr_queue_drained", q_rr.size(), 32'd0);
        chk("fp_queue_drained", q_fp.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
